// File: rtl/control_sequencer_p.sv
// control_sequencer_p: Moore control FSM sequencing load, fetch, decode and execute of a small CPU.
// Outputs are registered from the next state, so each strobe lines up with the state it belongs to.
module control_sequencer_p #(
  parameter int OPW     = 6,
  parameter int NREG    = 4,
  parameter int RSW     = 2,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bgn,
  input  logic            fin_file,
  input  logic [OPW-1:0]  opcode,
  input  logic [RSW-1:0]  rsel,
  input  logic [3:0]      cond_mask,
  input  logic [3:0]      flags,
  input  logic            unit_done,
  output logic            read_file,
  output logic            fetch,
  output logic            pc_inc,
  output logic            pc_load_imm,
  output logic            pc_load_mem,
  output logic [NREG-1:0] reg_rd_en,
  output logic [NREG-1:0] reg_wr_en,
  output logic            acc_rd,
  output logic            acc_wr,
  output logic            mem_read,
  output logic            mem_write,
  output logic            push,
  output logic            pop,
  output logic            alu_start,
  output logic            crypto_start,
  output logic            busy,
  output logic            fin,
  output logic            err,
  output logic [4:0]      state_dbg
);
  typedef enum logic [4:0] {
    IDLE, LOAD, FETCH, INC, DECODE, ST1, ST2, LD1, LD2, BR,
    CALL, RET1, RET2, EXEC, WAIT, WB, END, ERROR
  } state_t;
  state_t          state_q, state_d, dec_st;
  logic [OPW-1:0]  op_q, op_d;
  logic [RSW-1:0]  rs_q, rs_d;
  logic [3:0]      cm_q, cm_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [NREG-1:0] sel;
  logic            taken;
  always_comb begin
    op_d   = state_q == DECODE ? opcode : op_q;
    rs_d   = state_q == DECODE ? rsel : rs_q;
    cm_d   = state_q == DECODE ? cond_mask : cm_q;
    sel    = NREG'(1) << rs_d;
    taken  = cm_d == 4'd0 || (flags & cm_d) != 4'd0;
    dec_st = int'(rsel) >= NREG ? ERROR
           : opcode == OPW'(0) ? END
           : opcode == OPW'(1) || opcode == OPW'(3) ? ST1
           : opcode == OPW'(2) || opcode == OPW'(4) ? LD1
           : opcode == OPW'(5) ? BR
           : opcode == OPW'(6) ? CALL
           : opcode == OPW'(7) ? RET1
           : opcode <= OPW'(30) ? EXEC : ERROR;
    state_d = state_q;
    case (state_q)
      IDLE:                        state_d = bgn ? LOAD : IDLE;
      LOAD:                        state_d = fin_file ? FETCH : LOAD;
      FETCH:                       state_d = INC;
      INC:                         state_d = DECODE;
      DECODE:                      state_d = dec_st;
      ST1:                         state_d = ST2;
      LD1:                         state_d = LD2;
      RET1:                        state_d = RET2;
      EXEC:                        state_d = WAIT;
      WAIT:                        state_d = unit_done ? WB : cnt_q == 8'(TIMEOUT) ? ERROR : WAIT;
      ST2, LD2, BR, CALL, RET2, WB: state_d = FETCH;
      END, ERROR:                  state_d = bgn ? IDLE : state_q;
      default:                     state_d = IDLE;
    endcase
    // WAIT counts from 1 on entry so the TIMEOUT-th WAIT cycle is the last one
    cnt_d = state_d != WAIT ? 8'd0 : state_q == WAIT ? cnt_q + 8'd1 : 8'd1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      op_q         <= '0;
      rs_q         <= '0;
      cm_q         <= '0;
      cnt_q        <= '0;
      read_file    <= 1'b0;
      fetch        <= 1'b0;
      pc_inc       <= 1'b0;
      pc_load_imm  <= 1'b0;
      pc_load_mem  <= 1'b0;
      reg_rd_en    <= '0;
      reg_wr_en    <= '0;
      acc_rd       <= 1'b0;
      acc_wr       <= 1'b0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      push         <= 1'b0;
      pop          <= 1'b0;
      alu_start    <= 1'b0;
      crypto_start <= 1'b0;
      busy         <= 1'b0;
      fin          <= 1'b0;
      err          <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      rs_q         <= rs_d;
      cm_q         <= cm_d;
      cnt_q        <= cnt_d;
      read_file    <= state_d == LOAD;
      fetch        <= state_d == FETCH;
      pc_inc       <= state_d == INC;
      pc_load_imm  <= state_d == CALL || (state_d == BR && taken);
      pc_load_mem  <= state_d == RET2;
      reg_rd_en    <= state_d == EXEC || (state_d == ST1 && op_d == OPW'(1)) ? sel : '0;
      reg_wr_en    <= state_d == LD2 && op_d == OPW'(2) ? sel : '0;
      acc_rd       <= state_d == ST1 && op_d == OPW'(3);
      acc_wr       <= state_d == WB || (state_d == LD2 && op_d == OPW'(4));
      mem_read     <= state_d == LD1 || state_d == RET1;
      mem_write    <= state_d == ST2;
      push         <= state_d == CALL;
      pop          <= state_d == RET1;
      alu_start    <= state_d == EXEC && op_d != OPW'(30);
      crypto_start <= state_d == EXEC && op_d == OPW'(30);
      busy         <= !(state_d == IDLE || state_d == END || state_d == ERROR);
      fin          <= state_d == END;
      err          <= state_d == ERROR;
    end
  end
  assign state_dbg = state_q;
endmodule

// File: tb/tb_control_sequencer_p.sv
// tb_control_sequencer_p: scoreboard bench; each driven cycle queues the expected state and outputs.
module tb_control_sequencer_p;
  localparam int TIMEOUT = 16;
  localparam logic [4:0] S_IDLE = 5'd0, S_LOAD = 5'd1, S_FETCH = 5'd2, S_INC = 5'd3, S_DECODE = 5'd4,
    S_ST1 = 5'd5, S_ST2 = 5'd6, S_LD1 = 5'd7, S_LD2 = 5'd8, S_BR = 5'd9, S_CALL = 5'd10,
    S_RET1 = 5'd11, S_RET2 = 5'd12, S_EXEC = 5'd13, S_WAIT = 5'd14, S_WB = 5'd15,
    S_END = 5'd16, S_ERROR = 5'd17;
  localparam logic [23:0] RF = 24'h800000, FE = 24'h400000, PI = 24'h200000, PLI = 24'h100000,
    PLM = 24'h080000, ACR = 24'h000400, ACW = 24'h000200, MR = 24'h000100, MW = 24'h000080,
    PU = 24'h000040, PO = 24'h000020, AS = 24'h000010, CS = 24'h000008, BZ = 24'h000004,
    FN = 24'h000002, ER = 24'h000001;
  logic clk = 1'b0, rst, bgn, fin_file, unit_done;
  logic [5:0] opcode;
  logic [1:0] rsel;
  logic [3:0] cond_mask, flags;
  logic read_file, fetch, pc_inc, pc_load_imm, pc_load_mem, acc_rd, acc_wr, mem_read, mem_write;
  logic push, pop, alu_start, crypto_start, busy, fin, err;
  logic [3:0] reg_rd_en, reg_wr_en;
  logic [4:0] state_dbg;
  logic b_read_file, b_fetch, b_pc_inc, b_pc_load_imm, b_pc_load_mem, b_acc_rd, b_acc_wr;
  logic b_mem_read, b_mem_write, b_push, b_pop, b_alu_start, b_crypto_start, b_busy, b_fin, b_err;
  logic [2:0] b_reg_rd_en, b_reg_wr_en;
  logic [4:0] b_state_dbg;
  logic [23:0] ov;
  int vecs = 0, errs = 0;
  typedef struct {string nm; logic [4:0] st; logic [23:0] ov;} exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  control_sequencer_p #(.OPW(6), .NREG(4), .RSW(2), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .bgn(bgn), .fin_file(fin_file), .opcode(opcode), .rsel(rsel),
    .cond_mask(cond_mask), .flags(flags), .unit_done(unit_done), .read_file(read_file),
    .fetch(fetch), .pc_inc(pc_inc), .pc_load_imm(pc_load_imm), .pc_load_mem(pc_load_mem),
    .reg_rd_en(reg_rd_en), .reg_wr_en(reg_wr_en), .acc_rd(acc_rd), .acc_wr(acc_wr),
    .mem_read(mem_read), .mem_write(mem_write), .push(push), .pop(pop), .alu_start(alu_start),
    .crypto_start(crypto_start), .busy(busy), .fin(fin), .err(err), .state_dbg(state_dbg));
  control_sequencer_p #(.OPW(6), .NREG(3), .RSW(2), .TIMEOUT(TIMEOUT)) dut3 (
    .clk(clk), .rst(rst), .bgn(bgn), .fin_file(fin_file), .opcode(opcode), .rsel(rsel),
    .cond_mask(cond_mask), .flags(flags), .unit_done(unit_done), .read_file(b_read_file),
    .fetch(b_fetch), .pc_inc(b_pc_inc), .pc_load_imm(b_pc_load_imm), .pc_load_mem(b_pc_load_mem),
    .reg_rd_en(b_reg_rd_en), .reg_wr_en(b_reg_wr_en), .acc_rd(b_acc_rd), .acc_wr(b_acc_wr),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .push(b_push), .pop(b_pop),
    .alu_start(b_alu_start), .crypto_start(b_crypto_start), .busy(b_busy), .fin(b_fin),
    .err(b_err), .state_dbg(b_state_dbg));
  assign ov = {read_file, fetch, pc_inc, pc_load_imm, pc_load_mem, reg_rd_en, reg_wr_en, acc_rd,
               acc_wr, mem_read, mem_write, push, pop, alu_start, crypto_start, busy, fin, err};
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      vecs++;
      if (state_dbg !== e.st || ov !== e.ov) begin
        errs++;
        $display("FAIL %s: got state=%0d outs=%h, want state=%0d outs=%h", e.nm, state_dbg, ov, e.st, e.ov);
      end
    end
  end
  function automatic logic [23:0] rrd(input int r);
    return 24'h008000 << r;
  endfunction
  function automatic logic [23:0] rwr(input int r);
    return 24'h000800 << r;
  endfunction
  task automatic step(input string nm, input logic [4:0] st, input logic [23:0] o);
    q.push_back('{nm, st, o});
    @(negedge clk);
  endtask
  task automatic load_prog();
    bgn = 1'b1;
    step("load1", S_LOAD, RF | BZ);
    bgn = 1'b0;
    step("load2", S_LOAD, RF | BZ);
    step("load3", S_LOAD, RF | BZ);
    fin_file = 1'b1;
    step("first_fetch", S_FETCH, FE | BZ);
    fin_file = 1'b0;
  endtask
  task automatic fetch_to_decode(input logic [5:0] op, input logic [1:0] rs, input logic [3:0] cm, input logic [3:0] fl);
    opcode = op; rsel = rs; cond_mask = cm; flags = fl;
    step("inc", S_INC, PI | BZ);
    step("decode", S_DECODE, BZ);
  endtask
  task automatic test_reset();
    rst = 1'b1; bgn = 1'b1;
    step("reset", S_IDLE, 24'h0);
    step("reset_over_bgn", S_IDLE, 24'h0);
    rst = 1'b0; bgn = 1'b0;
    step("idle_hold", S_IDLE, 24'h0);
  endtask
  task automatic test_load_alu();
    load_prog();
    fetch_to_decode(6'd12, 2'd2, 4'd0, 4'd0);
    step("alu_exec", S_EXEC, AS | rrd(2) | BZ);
    opcode = 6'd30; rsel = 2'd0;
    step("alu_wait1", S_WAIT, BZ);
    step("alu_wait2", S_WAIT, BZ);
    step("alu_wait3", S_WAIT, BZ);
    unit_done = 1'b1;
    step("alu_wb", S_WB, ACW | BZ);
    unit_done = 1'b0;
    step("alu_next_fetch", S_FETCH, FE | BZ);
    fetch_to_decode(6'd0, 2'd0, 4'd0, 4'd0);
    step("end", S_END, FN);
    step("end_sticky", S_END, FN);
    bgn = 1'b1;
    step("end_to_idle", S_IDLE, 24'h0);
    bgn = 1'b0;
  endtask
  task automatic test_branch();
    load_prog();
    fetch_to_decode(6'd5, 2'd0, 4'b0001, 4'b0001);
    step("br_taken", S_BR, PLI | BZ);
    step("br_fetch", S_FETCH, FE | BZ);
    fetch_to_decode(6'd5, 2'd0, 4'b0001, 4'b0000);
    step("br_not_taken", S_BR, BZ);
    step("br_nt_fetch", S_FETCH, FE | BZ);
    fetch_to_decode(6'd5, 2'd0, 4'b0000, 4'b0000);
    step("br_mask0", S_BR, PLI | BZ);
    step("br_m0_fetch", S_FETCH, FE | BZ);
    fetch_to_decode(6'd5, 2'd0, 4'b1010, 4'b1000);
    step("br_carry", S_BR, PLI | BZ);
    step("br_c_fetch", S_FETCH, FE | BZ);
  endtask
  task automatic test_call_ret();
    fetch_to_decode(6'd6, 2'd0, 4'd0, 4'd0);
    step("call", S_CALL, PU | PLI | BZ);
    step("call_fetch", S_FETCH, FE | BZ);
    fetch_to_decode(6'd7, 2'd0, 4'd0, 4'd0);
    step("ret1", S_RET1, PO | MR | BZ);
    step("ret2", S_RET2, PLM | BZ);
    step("ret_fetch", S_FETCH, FE | BZ);
  endtask
  task automatic test_ld_st();
    fetch_to_decode(6'd1, 2'd1, 4'd0, 4'd0);
    step("st_reg1", S_ST1, rrd(1) | BZ);
    opcode = 6'd4; rsel = 2'd3;
    step("st_reg2", S_ST2, MW | BZ);
    step("st_reg_fetch", S_FETCH, FE | BZ);
    fetch_to_decode(6'd2, 2'd3, 4'd0, 4'd0);
    step("ld_reg1", S_LD1, MR | BZ);
    opcode = 6'd4; rsel = 2'd0;
    step("ld_reg2", S_LD2, rwr(3) | BZ);
    step("ld_reg_fetch", S_FETCH, FE | BZ);
    fetch_to_decode(6'd3, 2'd0, 4'd0, 4'd0);
    step("st_acc1", S_ST1, ACR | BZ);
    step("st_acc2", S_ST2, MW | BZ);
    step("st_acc_fetch", S_FETCH, FE | BZ);
    fetch_to_decode(6'd4, 2'd0, 4'd0, 4'd0);
    step("ld_acc1", S_LD1, MR | BZ);
    opcode = 6'd2;
    step("ld_acc2", S_LD2, ACW | BZ);
    step("ld_acc_fetch", S_FETCH, FE | BZ);
  endtask
  task automatic test_bgn_ignored();
    bgn = 1'b1;
    fetch_to_decode(6'd29, 2'd1, 4'd0, 4'd0);
    step("busy_exec", S_EXEC, AS | rrd(1) | BZ);
    step("busy_wait", S_WAIT, BZ);
    unit_done = 1'b1;
    step("busy_wb", S_WB, ACW | BZ);
    unit_done = 1'b0;
    step("busy_fetch", S_FETCH, FE | BZ);
    bgn = 1'b0;
  endtask
  task automatic test_timeout();
    fetch_to_decode(6'd30, 2'd0, 4'd0, 4'd0);
    step("crypto_exec", S_EXEC, CS | rrd(0) | BZ);
    for (int i = 0; i < TIMEOUT; i++) step("to_wait", S_WAIT, BZ);
    step("to_error", S_ERROR, ER);
    step("to_error_sticky", S_ERROR, ER);
    bgn = 1'b1;
    step("to_error_clear", S_IDLE, 24'h0);
    bgn = 1'b0;
    load_prog();
    fetch_to_decode(6'd30, 2'd1, 4'd0, 4'd0);
    step("dl_exec", S_EXEC, CS | rrd(1) | BZ);
    for (int i = 0; i < TIMEOUT; i++) step("dl_wait", S_WAIT, BZ);
    unit_done = 1'b1;
    step("done_at_limit", S_WB, ACW | BZ);
    unit_done = 1'b0;
    step("dl_fetch", S_FETCH, FE | BZ);
  endtask
  task automatic test_illegal();
    fetch_to_decode(6'd31, 2'd0, 4'd0, 4'd0);
    step("illegal31", S_ERROR, ER);
    bgn = 1'b1;
    step("ill_clear", S_IDLE, 24'h0);
    bgn = 1'b0;
    load_prog();
    fetch_to_decode(6'd63, 2'd0, 4'd0, 4'd0);
    step("illegal63", S_ERROR, ER);
    rst = 1'b1;
    step("ill_reset", S_IDLE, 24'h0);
    rst = 1'b0;
    load_prog();
    fetch_to_decode(6'd2, 2'd3, 4'd0, 4'd0);
    step("nreg4_ld1", S_LD1, MR | BZ);
    vecs++;
    if (b_state_dbg !== S_ERROR || b_err !== 1'b1 || {b_mem_read, b_mem_write, b_reg_rd_en, b_reg_wr_en,
        b_acc_rd, b_acc_wr, b_push, b_pop, b_pc_load_imm, b_pc_load_mem, b_alu_start, b_crypto_start} !== 16'h0) begin
      errs++;
      $display("FAIL nreg3_rsel3: got state=%0d err=%b rd=%b wr=%b mr=%b, want state=17 err=1 no strobes",
               b_state_dbg, b_err, b_reg_rd_en, b_reg_wr_en, b_mem_read);
    end
    step("nreg4_ld2", S_LD2, rwr(3) | BZ);
    step("nreg4_fetch", S_FETCH, FE | BZ);
  endtask
  task automatic test_reset_mid_wait();
    fetch_to_decode(6'd8, 2'd1, 4'd0, 4'd0);
    step("rw_exec", S_EXEC, AS | rrd(1) | BZ);
    step("rw_wait1", S_WAIT, BZ);
    step("rw_wait2", S_WAIT, BZ);
    rst = 1'b1; unit_done = 1'b1; bgn = 1'b1;
    step("rst_mid_wait", S_IDLE, 24'h0);
    rst = 1'b0; unit_done = 1'b0; bgn = 1'b0;
    step("rw_idle", S_IDLE, 24'h0);
    load_prog();
    fetch_to_decode(6'd8, 2'd0, 4'd0, 4'd0);
    step("rw2_exec", S_EXEC, AS | rrd(0) | BZ);
    for (int i = 0; i < TIMEOUT; i++) step("rw2_wait", S_WAIT, BZ);
    step("rw2_timeout", S_ERROR, ER);
    bgn = 1'b1;
    step("rw2_clear", S_IDLE, 24'h0);
    bgn = 1'b0;
    load_prog();
    fetch_to_decode(6'd0, 2'd0, 4'd0, 4'd0);
    step("end_fin", S_END, FN);
  endtask
  initial begin
    rst = 1'b1; bgn = 1'b0; fin_file = 1'b0; unit_done = 1'b0;
    opcode = '0; rsel = '0; cond_mask = '0; flags = '0;
    @(negedge clk);
    test_reset();
    test_load_alu();
    test_branch();
    test_call_ret();
    test_ld_st();
    test_bgn_ignored();
    test_timeout();
    test_illegal();
    test_reset_mid_wait();
    @(posedge clk);
    #2;
    vecs++;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
endmodule
